// File: rtl/row_deskew_buffer_if.sv
// rtl/row_deskew_buffer_if.sv - diagonal input and aligned-row output stream bundle
interface row_deskew_buffer_if #(
   parameter int LANES = 32,
   parameter int DW    = 16
);
   logic [LANES*DW-1:0] diag_in;
   logic                diag_valid;
   logic [LANES*DW-1:0] row_out;
   logic                row_valid;
   logic                row_ready;
   logic                row_last;

   modport master (
      output diag_in, diag_valid, row_ready,
      input  row_out, row_valid, row_last
   );

   modport slave (
      input  diag_in, diag_valid, row_ready,
      output row_out, row_valid, row_last
   );
endinterface

// File: rtl/row_deskew_buffer.sv
// rtl/row_deskew_buffer.sv - realigns a wavefront lane stream into whole rows and queues them
module row_deskew_buffer #(
   parameter int LANES         = 32,
   parameter int DW            = 16,
   parameter int FIFO_DEPTH    = 4,
   parameter int ROWS_PER_TILE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   row_deskew_buffer_if.slave   bus,
   output logic                 tile_done,
   output logic                 overflow,
   input  logic                 clr_overflow
);
   localparam int W   = LANES * DW;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int RCW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

   logic [LANES-2:0]      vpipe;
   logic [W-1:0]          aligned;
   logic [W-1:0]          mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_mem;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;
   logic [RCW-1:0]        row_cnt;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  wr_en;
   logic                  drop;
   logic                  row_is_last;

   // Lane i needs LANES-1-i stages so every lane of a row lines up with the last lane.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int D = LANES - 1 - i;
      if (D == 0) begin : g_direct
         assign aligned[i*DW +: DW] = bus.diag_in[i*DW +: DW];
      end else begin : g_sr
         logic [DW-1:0] sr [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) sr[k] <= '0;
            end else begin
               sr[0] <= bus.diag_in[i*DW +: DW];
               for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
            end
         end
         assign aligned[i*DW +: DW] = sr[D-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe <= '0;
      end else begin
         vpipe[0] <= bus.diag_valid;
         for (int k = 1; k < LANES - 1; k++) vpipe[k] <= vpipe[k-1];
      end
   end

   assign push        = vpipe[LANES-2];
   assign full        = (count == (PW+1)'(FIFO_DEPTH));
   assign pop         = bus.row_valid & bus.row_ready;
   assign wr_en       = push & (~full | pop);
   assign drop        = push & full & ~pop;
   assign row_is_last = (row_cnt == RCW'(ROWS_PER_TILE - 1));

   assign bus.row_valid = (count != '0);
   assign bus.row_out   = bus.row_valid ? mem[rd_ptr] : '0;
   assign bus.row_last  = bus.row_valid & last_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= aligned;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_mem  <= '0;
         row_cnt   <= '0;
         tile_done <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wr_en) begin
            last_mem[wr_ptr] <= row_is_last;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         // Dropped rows still advance the counter so tile framing stays intact.
         if (push) row_cnt <= row_is_last ? '0 : row_cnt + RCW'(1);
         tile_done <= pop & last_mem[rd_ptr];
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_row_deskew_buffer.sv
// tb/tb_row_deskew_buffer.sv - scoreboard bench for row_deskew_buffer
module tb_row_deskew_buffer;
   localparam int LANES = 32;
   localparam int DW    = 16;
   localparam int W     = LANES * DW;
   localparam int RPT   = 32;

   typedef struct packed {
      logic         last;
      logic [W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr_overflow = 1'b0;
   logic tile_done;
   logic overflow;

   row_deskew_buffer_if #(.LANES(LANES), .DW(DW)) bus ();

   row_deskew_buffer #(
      .LANES(LANES), .DW(DW), .FIFO_DEPTH(4), .ROWS_PER_TILE(RPT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .tile_done(tile_done), .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   exp_t         sb [$];
   logic [W-1:0] hist_d [$];
   bit           hist_v [$];
   int           rowcnt;
   int           n_vec;
   int           n_err;
   bit           exp_td;
   exp_t         mon_e;

   always @(negedge clk) begin
      if (rst) begin
         exp_td = 1'b0;
      end else begin
         n_vec++;
         if (tile_done !== exp_td) begin
            n_err++;
            $display("FAIL tile_done got %b exp %b", tile_done, exp_td);
         end
         exp_td = 1'b0;
         if (bus.row_valid === 1'b1 && bus.row_ready === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_row got %h exp none", bus.row_out);
            end else begin
               mon_e = sb.pop_front();
               n_vec++;
               if (bus.row_out !== mon_e.data) begin
                  n_err++;
                  $display("FAIL row_data got %h exp %h", bus.row_out, mon_e.data);
               end
               if (bus.row_last !== mon_e.last) begin
                  n_err++;
                  $display("FAIL row_last got %b exp %b", bus.row_last, mon_e.last);
               end
               exp_td = mon_e.last;
            end
         end
      end
   end

   function automatic logic [W-1:0] rnd_row();
      logic [W-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = 16'($urandom);
      r[0 +: DW]    = 16'h7E01;
      r[DW +: DW]   = 16'hFC00;
      r[2*DW +: DW] = 16'h0001;
      return r;
   endfunction

   // One cycle of wavefront stimulus: lane i carries the row launched i cycles ago.
   task automatic step(input bit v, input logic [W-1:0] d, input bit expect_out);
      logic [W-1:0] din;
      hist_v.push_front(v);
      hist_d.push_front(d);
      if (hist_v.size() > LANES) begin
         void'(hist_v.pop_back());
         void'(hist_d.pop_back());
      end
      for (int i = 0; i < LANES; i++) begin
         if (i < hist_v.size() && hist_v[i]) din[i*DW +: DW] = hist_d[i][i*DW +: DW];
         else                                din[i*DW +: DW] = 16'($urandom);
      end
      bus.diag_in    = din;
      bus.diag_valid = v;
      if (v) begin
         if (expect_out) sb.push_back('{last: (rowcnt == RPT-1), data: d});
         rowcnt = (rowcnt + 1) % RPT;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.diag_valid = 1'b0;
      bus.row_ready  = 1'b0;
      clr_overflow   = 1'b0;
      sb.delete();
      hist_v.delete();
      hist_d.delete();
      rowcnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec += 5;
      if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL rst_row_valid got %b exp 0", bus.row_valid); end
      if (bus.row_last !== 1'b0)  begin n_err++; $display("FAIL rst_row_last got %b exp 0", bus.row_last); end
      if (tile_done !== 1'b0)     begin n_err++; $display("FAIL rst_tile_done got %b exp 0", tile_done); end
      if (overflow !== 1'b0)      begin n_err++; $display("FAIL rst_overflow got %b exp 0", overflow); end
      if (bus.row_out !== '0)     begin n_err++; $display("FAIL rst_row_out got %h exp 0", bus.row_out); end
   endtask

   task automatic test_single();
      logic [W-1:0] d;
      int lat = 0;
      int seen = 0;
      do_reset();
      bus.row_ready = 1'b1;
      for (int i = 0; i < LANES; i++) d[i*DW +: DW] = 16'h3C00 + 16'(i);
      for (int s = 0; s < 45; s++) begin
         step(s == 0, d, 1'b1);
         if (bus.row_valid === 1'b1) begin
            if (seen == 0) lat = s + 1;
            seen++;
         end
      end
      n_vec += 3;
      if (lat != LANES)    begin n_err++; $display("FAIL single_latency got %0d exp %0d", lat, LANES); end
      if (seen != 1)       begin n_err++; $display("FAIL single_count got %0d exp 1", seen); end
      if (sb.size() != 0)  begin n_err++; $display("FAIL single_pending got %0d exp 0", sb.size()); end
   endtask

   task automatic test_burst();
      logic [W-1:0] d;
      do_reset();
      bus.row_ready = 1'b1;
      for (int r = 0; r < 32; r++) begin
         for (int i = 0; i < LANES; i++) d[i*DW +: DW] = {8'(r), 8'(i)};
         step(1'b1, d, 1'b1);
      end
      repeat (40) step(1'b0, '0, 1'b1);
      n_vec += 2;
      if (sb.size() != 0)   begin n_err++; $display("FAIL burst_pending got %0d exp 0", sb.size()); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_overflow got %b exp 0", overflow); end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.row_ready = 1'b0;
      repeat (4) step(1'b1, rnd_row(), 1'b1);
      repeat (34) step(1'b0, '0, 1'b1);
      n_vec += 2;
      if (overflow !== 1'b0)      begin n_err++; $display("FAIL bp_full_overflow got %b exp 0", overflow); end
      if (bus.row_valid !== 1'b1) begin n_err++; $display("FAIL bp_full_valid got %b exp 1", bus.row_valid); end
      step(1'b1, rnd_row(), 1'b0);
      repeat (34) step(1'b0, '0, 1'b1);
      n_vec++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_drop_overflow got %b exp 1", overflow); end
      bus.row_ready = 1'b1;
      repeat (8) step(1'b0, '0, 1'b1);
      n_vec += 2;
      if (sb.size() != 0)         begin n_err++; $display("FAIL bp_pending got %0d exp 0", sb.size()); end
      if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained_valid got %b exp 0", bus.row_valid); end
      clr_overflow = 1'b1;
      step(1'b0, '0, 1'b1);
      clr_overflow = 1'b0;
      n_vec++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_clr_overflow got %b exp 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int s = 0; s < 50; s++) begin
         bus.row_ready = (s >= 35);
         if (s == 35) begin
            n_vec++;
            if (bus.row_valid !== 1'b1) begin n_err++; $display("FAIL fpp_valid got %b exp 1", bus.row_valid); end
         end
         step(s < 5, (s < 5) ? rnd_row() : '0, 1'b1);
      end
      n_vec += 2;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
      if (sb.size() != 0)    begin n_err++; $display("FAIL fpp_pending got %0d exp 0", sb.size()); end
   endtask

   task automatic test_gap();
      int first = -1;
      int second = -1;
      int seen = 0;
      bit v;
      do_reset();
      bus.row_ready = 1'b1;
      for (int s = 0; s < 45; s++) begin
         v = (s == 0) || (s == 3);
         step(v, v ? rnd_row() : '0, 1'b1);
         if (bus.row_valid === 1'b1) begin
            if (seen == 0) first = s;
            else if (seen == 1) second = s;
            seen++;
         end
      end
      n_vec += 3;
      if (seen != 2)    begin n_err++; $display("FAIL gap_count got %0d exp 2", seen); end
      if (first != 31)  begin n_err++; $display("FAIL gap_first got %0d exp 31", first); end
      if (second != 34) begin n_err++; $display("FAIL gap_second got %0d exp 34", second); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      do_reset();
      bus.row_ready = 1'b1;
      for (int s = 0; s < 36; s++) step(s < 20, (s < 20) ? rnd_row() : '0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      n_vec += 4;
      if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", bus.row_valid); end
      if (bus.row_out !== '0)     begin n_err++; $display("FAIL mid_rst_row_out got %h exp 0", bus.row_out); end
      if (bus.row_last !== 1'b0)  begin n_err++; $display("FAIL mid_rst_row_last got %b exp 0", bus.row_last); end
      if (tile_done !== 1'b0)     begin n_err++; $display("FAIL mid_rst_tile_done got %b exp 0", tile_done); end
      sb.delete();
      hist_v.delete();
      hist_d.delete();
      rowcnt = 0;
      bus.diag_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 45; s++) begin
         step(s == 0, rnd_row(), 1'b1);
         if (bus.row_valid === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 1) begin n_err++; $display("FAIL mid_single_count got %0d exp 1", seen); end
      repeat (31) step(1'b1, rnd_row(), 1'b1);
      repeat (40) step(1'b0, '0, 1'b1);
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL mid_pending got %0d exp 0", sb.size()); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rowcnt = 0;
      bus.diag_in    = '0;
      bus.diag_valid = 1'b0;
      bus.row_ready  = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_full_push_pop();
      test_gap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
